tuning_word_set: RTL and testbench
==================================

Name: tuning_word_set

Overview:
Pushbutton editor for the DDS phase-accumulator tuning word, one hex digit at a time. Debounces three active-low keys and maintains the tuning word register. Drives the downstream hex converter with the 4-bit value of the currently selected digit. Also outputs the full tuning word to the phase accumulator.

Parameters:
TW_WIDTH, 24, tuning word width; must be a multiple of 4. NUM_DIGITS = TW_WIDTH/4 is derived, not overridable.
DEBOUNCE_CYCLES, 500000, clocks a key level must stay stable before it is accepted (10 ms at 50 MHz). Minimum 2.
SEL_WIDTH, 3, width of digit_sel; must satisfy 2^SEL_WIDTH >= NUM_DIGITS.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
key_inc  in  1  active-low pushbutton, asynchronous to clk; increments selected digit
key_dec  in  1  active-low pushbutton, asynchronous; decrements selected digit
key_sel  in  1  active-low pushbutton, asynchronous; advances digit selection
tuning_word  out  TW_WIDTH  current tuning word, registered
digit_sel  out  SEL_WIDTH  index of digit being edited; 0 = least-significant nibble
count  out  4  tuning_word[4*digit_sel +: 4], registered; feeds the hex converter
word_changed  out  1  one-cycle pulse when tuning_word changes value

Behaviour:
- Reset, asynchronous, reset==0:
  - tuning_word=0, digit_sel=0, count=0, word_changed=0.
  - All debounce FSMs return to RELEASED. Counters and synchronizer flops are set to 1 (released).
- Key path, per key:
  - 2-flop synchronizer, then debounce FSM, then one-cycle press pulse.
- Debounce FSM states:
  - RELEASED: sync==0 -> CHK_PRESS, counter cleared.
  - CHK_PRESS: sync==1 -> RELEASED. Counter reaching DEBOUNCE_CYCLES-1 -> PRESSED, emitting press pulse for exactly one clk.
  - PRESSED: sync==1 -> CHK_RELEASE, counter cleared.
  - CHK_RELEASE: sync==0 -> PRESSED. Counter reaching DEBOUNCE_CYCLES-1 -> RELEASED.
- No auto-repeat: a held key yields exactly one pulse.
- Glitches shorter than DEBOUNCE_CYCLES never produce a pulse.
- Latency: 2 cycles sync + DEBOUNCE_CYCLES to pulse; tuning_word/count update on the next edge.
- Edit rules, applied on press pulses in the same cycle:
  - inc only: selected nibble +1 mod 16; F wraps to 0. No carry into neighbouring nibbles.
  - dec only: selected nibble -1 mod 16; 0 wraps to F. No borrow.
  - inc and dec together: no change, word_changed stays 0.
  - sel: digit_sel+1; NUM_DIGITS-1 wraps to 0.
  - sel with inc/dec in the same cycle: the edit applies to the old digit_sel; digit_sel advances on the same edge.
- count is recomputed every cycle from the next-state tuning_word and digit_sel. It therefore always matches the displayed digit with no stale cycle.
- word_changed=1 for one cycle after any edge on which tuning_word changed; otherwise 0.
- Reset asserted mid-debounce: all state is discarded. After release, a key still held low must complete a full CHK_PRESS period before it generates a pulse.

Decomposition:
- Shared package tuning_pkg holds:
  - debounce state encoding: RELEASED=2'd0, CHK_PRESS=2'd1, PRESSED=2'd2, CHK_RELEASE=2'd3;
  - default TW_WIDTH and DEBOUNCE_CYCLES constants, shared with the phase accumulator.
- Sub-module key_debounce (params DEBOUNCE_CYCLES; ports clk, reset, key_n, press_pulse) contains the synchronizer, FSM and counter. It is instantiated three times.
- The top level holds the edit datapath and the digit_sel counter.

Test Plan:
DEBOUNCE_CYCLES=4 throughout.
1. Reset -> tuning_word=0, digit_sel=0, count=0, word_changed=0. Holding key_inc low through reset release -> first pulse no earlier than 6 cycles after reset release.
2. Digit 0 at value 0, key_inc held low for 20 cycles -> tuning_word=24'h000001, count=1, word_changed high for exactly 1 cycle, no repeat. 3-cycle low glitch on key_inc -> no change.
3. Digit 0 at 0, press key_dec -> nibble wraps to F, tuning_word=24'h00000F, count=F. Then 16 inc presses -> 24'h00000F again, nibble 1 still 0 (no carry).
4. Press key_sel 6 times, checking digit_sel 1,2,3,4,5,0. With digit_sel=5, press inc twice -> tuning_word=24'h200000, count=2.
5. Force key_inc and key_dec pulses in the same cycle -> tuning_word unchanged, word_changed=0. Force sel+inc in the same cycle with digit_sel=0 -> nibble 0 incremented, digit_sel=1, count shows nibble 1.
6. Assert reset at tuning_word=24'hABCDEF, digit_sel=3 -> all outputs 0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/tuning_pkg.sv
// Shared types and defaults for the DDS tuning-word editor.
// Debounce state encoding plus width/timing defaults used by the NCO.
package tuning_pkg;

  localparam int TW_WIDTH_DEF        = 24;
  localparam int DEBOUNCE_CYCLES_DEF = 500000;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    CHK_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    CHK_RELEASE = 2'd3
  } db_state_t;

endpackage

// File: rtl/key_debounce.sv
// Synchronizes and debounces one active-low key; one-clk press pulse.
// Ports: clk, reset (async, active-low), key_n (raw key), press_pulse.
module key_debounce
  import tuning_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic      meta;
  logic      sync;
  db_state_t state;
  db_state_t state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      sync <= 1'b1;
    end else begin
      meta <= key_n;
      sync <= meta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RELEASED;
      cnt   <= CW'(1);
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Pulse is Mealy: it fires in the last stable cycle so the
  // editor updates on the very next edge.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    press_pulse = 1'b0;
    unique case (state)
      RELEASED: begin
        if (!sync) begin
          state_n = CHK_PRESS;
          cnt_n   = '0;
        end
      end
      CHK_PRESS: begin
        if (sync) begin
          state_n = RELEASED;
        end else if (cnt == LAST) begin
          state_n     = PRESSED;
          press_pulse = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      PRESSED: begin
        if (sync) begin
          state_n = CHK_RELEASE;
          cnt_n   = '0;
        end
      end
      CHK_RELEASE: begin
        if (!sync) begin
          state_n = PRESSED;
        end else if (cnt == LAST) begin
          state_n = RELEASED;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = RELEASED;
    endcase
  end

endmodule

// File: rtl/tuning_word_set.sv
// Hex-digit pushbutton editor for the DDS tuning word.
// Ports: clk, reset (async, active-low), key_inc/key_dec/key_sel
// (active-low), tuning_word, digit_sel, count, word_changed.
module tuning_word_set
  import tuning_pkg::*;
#(
  parameter int TW_WIDTH        = TW_WIDTH_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SEL_WIDTH       = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 key_inc,
  input  logic                 key_dec,
  input  logic                 key_sel,
  output logic [TW_WIDTH-1:0]  tuning_word,
  output logic [SEL_WIDTH-1:0] digit_sel,
  output logic [3:0]           count,
  output logic                 word_changed
);

  localparam int NUM_DIGITS = TW_WIDTH / 4;
  localparam logic [SEL_WIDTH-1:0] SEL_LAST = SEL_WIDTH'(NUM_DIGITS - 1);

  logic inc_p;
  logic dec_p;
  logic sel_p;

  logic [TW_WIDTH-1:0]  tw_n;
  logic [SEL_WIDTH-1:0] sel_n;
  logic [3:0]           count_n;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .clk(clk), .reset(reset), .key_n(key_inc), .press_pulse(inc_p)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (
    .clk(clk), .reset(reset), .key_n(key_dec), .press_pulse(dec_p)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel (
    .clk(clk), .reset(reset), .key_n(key_sel), .press_pulse(sel_p)
  );

  // Edit uses the old digit_sel; count follows the new word and
  // new selection so the display never lags by a cycle.
  always_comb begin
    tw_n    = tuning_word;
    sel_n   = digit_sel;
    count_n = '0;
    if (inc_p ^ dec_p) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (digit_sel == SEL_WIDTH'(i)) begin
          tw_n[4*i +: 4] = inc_p ? tuning_word[4*i +: 4] + 4'd1
                                 : tuning_word[4*i +: 4] - 4'd1;
        end
      end
    end
    if (sel_p) begin
      sel_n = (digit_sel == SEL_LAST) ? '0
                                      : digit_sel + SEL_WIDTH'(1);
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel_n == SEL_WIDTH'(i)) begin
        count_n = tw_n[4*i +: 4];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tuning_word  <= '0;
      digit_sel    <= '0;
      count        <= '0;
      word_changed <= 1'b0;
    end else begin
      tuning_word  <= tw_n;
      digit_sel    <= sel_n;
      count        <= count_n;
      word_changed <= (tw_n != tuning_word);
    end
  end

endmodule

// File: tb/tb_tuning_word_set.sv
// Directed bench for tuning_word_set with DEBOUNCE_CYCLES=4.
// Drives keys on negedge, samples outputs on negedge.
module tb_tuning_word_set;

  logic        clk;
  logic        reset;
  logic        key_inc;
  logic        key_dec;
  logic        key_sel;
  logic [23:0] tuning_word;
  logic [2:0]  digit_sel;
  logic [3:0]  count;
  logic        word_changed;

  int errs   = 0;
  int checks = 0;
  int wc_cnt = 0;

  tuning_word_set #(
    .TW_WIDTH(24),
    .DEBOUNCE_CYCLES(4),
    .SEL_WIDTH(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_inc(key_inc),
    .key_dec(key_dec),
    .key_sel(key_sel),
    .tuning_word(tuning_word),
    .digit_sel(digit_sel),
    .count(count),
    .word_changed(word_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset && word_changed) wc_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic press(input logic i, input logic d, input logic s);
    @(negedge clk);
    key_inc = ~i;
    key_dec = ~d;
    key_sel = ~s;
    repeat (10) @(negedge clk);
    key_inc = 1'b1;
    key_dec = 1'b1;
    key_sel = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  int n;
  int wc0;
  bit found;

  initial begin
    reset   = 1'b0;
    key_inc = 1'b0;
    key_dec = 1'b1;
    key_sel = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tw", tuning_word, 0);
    chk("rst_sel", digit_sel, 0);
    chk("rst_count", count, 0);
    chk("rst_wc", word_changed, 0);

    // key_inc held low across reset release
    reset = 1'b1;
    n = 0;
    found = 0;
    while (!found && n < 30) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (word_changed) found = 1;
    end
    chk("t1_pulse_seen", found, 1);
    chk("t1_latency_min", n >= 6, 1);
    chk("t1_latency_max", n <= 8, 1);
    repeat (5) @(negedge clk);
    key_inc = 1'b1;
    repeat (10) @(negedge clk);

    // Test 2: held inc, single pulse; then glitch
    do_reset();
    wc0 = wc_cnt;
    key_inc = 1'b0;
    repeat (20) @(negedge clk);
    key_inc = 1'b1;
    repeat (10) @(negedge clk);
    chk("t2_tw", tuning_word, 24'h000001);
    chk("t2_count", count, 4'h1);
    chk("t2_wc_once", wc_cnt - wc0, 1);
    wc0 = wc_cnt;
    key_inc = 1'b0;
    repeat (3) @(negedge clk);
    key_inc = 1'b1;
    repeat (15) @(negedge clk);
    chk("t2_glitch_tw", tuning_word, 24'h000001);
    chk("t2_glitch_wc", wc_cnt - wc0, 0);

    // Test 3: dec wrap, then 16 incs without carry
    press(0, 1, 0);
    chk("t3_zero", tuning_word, 24'h000000);
    press(0, 1, 0);
    chk("t3_wrap_tw", tuning_word, 24'h00000F);
    chk("t3_wrap_count", count, 4'hF);
    for (int k = 0; k < 16; k++) press(1, 0, 0);
    chk("t3_inc16_tw", tuning_word, 24'h00000F);
    chk("t3_nib1", tuning_word[7:4], 4'h0);

    // Test 4: digit selection wrap
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      press(0, 0, 1);
      chk($sformatf("t4_sel%0d", k), digit_sel, k % 6);
    end
    for (int k = 0; k < 5; k++) press(0, 0, 1);
    chk("t4_sel5", digit_sel, 5);
    press(1, 0, 0);
    press(1, 0, 0);
    chk("t4_tw", tuning_word, 24'h200000);
    chk("t4_count", count, 4'h2);

    // Test 5: inc+dec together, then sel+inc together
    wc0 = wc_cnt;
    press(1, 1, 0);
    chk("t5_both_tw", tuning_word, 24'h200000);
    chk("t5_both_wc", wc_cnt - wc0, 0);
    press(0, 0, 1);
    press(0, 0, 1);
    for (int k = 0; k < 3; k++) press(1, 0, 0);
    chk("t5_setup_tw", tuning_word, 24'h200030);
    for (int k = 0; k < 5; k++) press(0, 0, 1);
    chk("t5_setup_sel", digit_sel, 0);
    @(negedge clk);
    key_inc = 1'b0;
    key_sel = 1'b0;
    n = 0;
    found = 0;
    while (!found && n < 20) begin
      @(negedge clk);
      n++;
      if (word_changed) found = 1;
    end
    chk("t5_si_seen", found, 1);
    chk("t5_si_tw", tuning_word, 24'h200031);
    chk("t5_si_sel", digit_sel, 1);
    chk("t5_si_count", count, 4'h3);
    key_inc = 1'b1;
    key_sel = 1'b1;
    repeat (10) @(negedge clk);

    // Test 6: build ABCDEF at digit 3, then async reset
    do_reset();
    for (int d = 0; d < 6; d++) begin
      for (int k = 0; k <= d; k++) press(0, 1, 0);
      press(0, 0, 1);
    end
    for (int k = 0; k < 3; k++) press(0, 0, 1);
    chk("t6_tw", tuning_word, 24'hABCDEF);
    chk("t6_sel", digit_sel, 3);
    chk("t6_count", count, 4'hC);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("t6_async_tw", tuning_word, 0);
    chk("t6_async_sel", digit_sel, 0);
    chk("t6_async_count", count, 0);
    chk("t6_async_wc", word_changed, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
